// File: rtl/spi_slave_cfg.sv
// SPI slave, parameterised mode and bit order, with a one-entry TX holding register and an RX output register.
// rx word appears 4 clk after the final sample SCK edge; tx_ready throttles the producer; an unread rx word is overwritten and overrun pulses.
`timescale 1ns/1ps
module spi_slave_cfg #(
  parameter int SIZE      = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sck,
  input  logic            cs,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe,
  input  logic [SIZE-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [SIZE-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            overrun,
  output logic            underrun,
  output logic            busy
);

  localparam int            CW       = $clog2(SIZE);
  localparam logic [CW-1:0] LAST     = CW'(SIZE - 1);
  localparam logic          IDLE_LVL = (CPOL != 0);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      sck_sync, cs_sync, mosi_sync;
  logic            sck_d;
  logic [2:0]      arm;
  logic            armed, cs_act, sck_chg, lead_e, trail_e;
  logic            sample_e, shift_e, load_e, shift_only;
  logic            load_first, in_word;
  logic [CW-1:0]   bit_cnt;
  logic [SIZE-1:0] tx_shift, rx_shift, hold_data;
  logic            hold_full, done_p;

  // arm holds off edge/cs detection until the synchronisers have refilled after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      arm       <= '0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      cs_sync   <= {cs_sync[0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_d     <= sck_sync[1];
      arm       <= {arm[1:0], 1'b1};
    end
  end

  assign armed   = arm[2];
  assign cs_act  = armed & ~cs_sync[1];
  assign sck_chg = armed & (sck_sync[1] != sck_d);
  assign lead_e  = sck_chg & (sck_sync[1] != IDLE_LVL);
  assign trail_e = sck_chg & (sck_sync[1] == IDLE_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_act) state_nxt = LOAD;
      LOAD:    state_nxt = cs_act ? ACTIVE : IDLE;
      ACTIVE:  if (!cs_act) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // with CPHA=1 the first word loads on the first leading edge, not in LOAD
  always_comb begin
    load_first = 1'b0;
    in_word    = 1'b0;
    case (state)
      LOAD:    load_first = cs_act && (CPHA == 0);
      ACTIVE:  in_word    = cs_act;
      default: ;
    endcase
  end

  assign sample_e   = in_word & ((CPHA != 0) ? trail_e : lead_e);
  assign shift_e    = in_word & ((CPHA != 0) ? lead_e : trail_e);
  assign load_e     = load_first | (shift_e & (bit_cnt == '0));
  assign shift_only = shift_e & (bit_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      done_p    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done_p   <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      if (!cs_act) begin
        bit_cnt  <= '0;
        tx_shift <= '0;
      end else begin
        if (sample_e) begin
          rx_shift <= (LSB_FIRST != 0) ? {mosi_sync[1], rx_shift[SIZE-1:1]}
                                       : {rx_shift[SIZE-2:0], mosi_sync[1]};
          bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
          done_p   <= (bit_cnt == LAST);
        end
        if (load_e) begin
          tx_shift <= hold_full ? hold_data : '0;
          underrun <= ~hold_full;
        end else if (shift_only) begin
          tx_shift <= (LSB_FIRST != 0) ? {1'b0, tx_shift[SIZE-1:1]}
                                       : {tx_shift[SIZE-2:0], 1'b0};
        end
      end
      // a word accepted in the same cycle as an empty load is kept for the next word
      if (load_e && cs_act && hold_full) hold_full <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (done_p) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign miso_oe  = cs_act;
  assign busy     = cs_act;
  assign miso     = cs_act & ((LSB_FIRST != 0) ? tx_shift[0] : tx_shift[SIZE-1]);

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: four instances (mode 0 MSB-first, modes 1-3 LSB-first) driven by a bit-banged SPI master.
// Expected miso/rx words are queued as stimulus is driven and compared against what each instance delivers.
`timescale 1ns/1ps
module tb_spi_slave_cfg;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mosi;
  logic [3:0] sck, cs, tx_valid, rx_ready;
  logic [3:0] miso, miso_oe, tx_ready, rx_valid, overrun, underrun, busy;
  logic [7:0] tx_data [4];
  logic [7:0] rx_data [4];

  int n_chk = 0;
  int n_pass = 0;
  int act = 0;
  int ur_cnt = 0, or_cnt = 0, rv_cnt = 0;
  logic rv_prev = 1'b0;
  logic [7:0] miso_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_cfg #(
      .SIZE(8), .CPOL(g / 2), .CPHA(g % 2), .LSB_FIRST((g != 0) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .sck(sck[g]), .cs(cs[g]), .mosi(mosi),
      .miso(miso[g]), .miso_oe(miso_oe[g]),
      .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
      .overrun(overrun[g]), .underrun(underrun[g]), .busy(busy[g])
    );
  end

  // delivered words and pulse counts for the instance under test
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid[act] && rx_ready[act]) got_q.push_back(rx_data[act]);
      if (rx_valid[act] && !rv_prev) rv_cnt++;
      if (underrun[act]) ur_cnt++;
      if (overrun[act]) or_cnt++;
    end
    rv_prev = rx_valid[act];
  end

  initial begin
    #500us;
    $display("FAIL watchdog: time %0t, limit 500us", $time);
    $fatal(1, "bench timeout");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sck = 4'b1100;
    cs = 4'hF;
    tx_valid = 4'h0;
    rx_ready = 4'hF;
    mosi = 1'b0;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    got_q.delete(); miso_exp.delete(); rx_exp.delete();
    ur_cnt = 0; or_cnt = 0; rv_cnt = 0;
  endtask

  task automatic push_tx(input int g, input logic [7:0] d);
    int t = 0;
    while (!tx_ready[g] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready[g]) begin
      n_chk++;
      $display("FAIL push_tx_timeout: tx_ready=%b required 1", tx_ready[g]);
    end else begin
      tx_data[g] = d;
      tx_valid[g] = 1'b1;
      @(negedge clk);
      tx_valid[g] = 1'b0;
    end
  endtask

  task automatic cs_low(input int g);
    cs[g] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high(input int g);
    cs[g] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input int g, input logic [7:0] din, input int nbits, output logic [7:0] cap);
    logic pol, cpha, lsb;
    int idx;
    pol = (g >= 2);
    cpha = (g % 2 == 1);
    lsb = (g != 0);
    cap = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi = din[idx];
        repeat (HALF) @(negedge clk);
        cap[idx] = miso[g];
        sck[g] = ~pol;
        repeat (HALF) @(negedge clk);
        sck[g] = pol;
      end else begin
        sck[g] = ~pol;
        mosi = din[idx];
        repeat (HALF) @(negedge clk);
        cap[idx] = miso[g];
        sck[g] = pol;
      end
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    act = 0;
    do_reset();
    n_chk++;
    if ({tx_ready[0], rx_valid[0], miso[0], miso_oe[0], busy[0], overrun[0], underrun[0]} !== 7'b1000000)
      $display("FAIL reset_flags: got %b required 1000000",
               {tx_ready[0], rx_valid[0], miso[0], miso_oe[0], busy[0], overrun[0], underrun[0]});
    else n_pass++;
    n_chk++;
    if (rx_data[0] !== 8'h00) $display("FAIL reset_rx_data: got %h required 00", rx_data[0]);
    else n_pass++;
    n_chk++;
    if ({tx_ready, busy, miso_oe} !== 12'hF00)
      $display("FAIL reset_all_modes: got %h required f00", {tx_ready, busy, miso_oe});
    else n_pass++;
  endtask

  task automatic test_mode0();
    logic [7:0] cap, e;
    act = 0;
    do_reset();
    push_tx(0, 8'hA5); miso_exp.push_back(8'hA5);
    cs_low(0);
    n_chk++;
    if ({busy[0], miso_oe[0]} !== 2'b11) $display("FAIL mode0_busy: got %b required 11", {busy[0], miso_oe[0]});
    else n_pass++;
    rx_exp.push_back(8'h3C);
    xfer(0, 8'h3C, 8, cap);
    cs_high(0);
    e = miso_exp.pop_front();
    n_chk++;
    if (cap !== e) $display("FAIL mode0_miso: got %h required %h", cap, e);
    else n_pass++;
    n_chk++;
    if (got_q.size() != 1) $display("FAIL mode0_rx_count: got %0d required 1", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && rx_exp.size() > 0) begin
      e = rx_exp.pop_front(); cap = got_q.pop_front();
      n_chk++;
      if (cap !== e) $display("FAIL mode0_rx: got %h required %h", cap, e);
      else n_pass++;
    end
    n_chk++;
    if (rv_cnt != 1 || busy[0] !== 1'b0) $display("FAIL mode0_valid_busy: got %0d/%b required 1/0", rv_cnt, busy[0]);
    else n_pass++;
  endtask

  task automatic test_modes();
    logic [7:0] cap, e, txw;
    for (int g = 1; g < 4; g++) begin
      act = g;
      do_reset();
      txw = 8'h6B ^ 8'(g << 5);
      push_tx(g, txw); miso_exp.push_back(txw);
      cs_low(g);
      rx_exp.push_back(8'h01);
      xfer(g, 8'h01, 8, cap);
      cs_high(g);
      e = miso_exp.pop_front();
      n_chk++;
      if (cap !== e) $display("FAIL mode%0d_miso: got %h required %h", g, cap, e);
      else n_pass++;
      e = rx_exp.pop_front();
      n_chk++;
      if (got_q.size() != 1 || got_q[0] !== e)
        $display("FAIL mode%0d_rx: got %h (n=%0d) required %h", g, rx_data[g], got_q.size(), e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cap, e;
    logic [7:0] words [3];
    words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
    act = 0;
    do_reset();
    push_tx(0, 8'hC3); miso_exp.push_back(8'hC3);
    miso_exp.push_back(8'h00);
    miso_exp.push_back(8'h7E);
    cs_low(0);
    for (int w = 0; w < 3; w++) begin
      rx_exp.push_back(words[w]);
      xfer(0, words[w], 8, cap);
      if (w == 0) push_tx(0, 8'h7E);
      if (w == 1) push_tx(0, 8'h81);
      e = miso_exp.pop_front();
      n_chk++;
      if (cap !== e) $display("FAIL b2b_miso_word%0d: got %h required %h", w + 1, cap, e);
      else n_pass++;
    end
    cs_high(0);
    n_chk++;
    if (ur_cnt != 1) $display("FAIL b2b_underrun: got %0d pulses required 1", ur_cnt);
    else n_pass++;
    n_chk++;
    if (got_q.size() != 3) $display("FAIL b2b_rx_count: got %0d required 3", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && rx_exp.size() > 0) begin
      e = rx_exp.pop_front(); cap = got_q.pop_front();
      n_chk++;
      if (cap !== e) $display("FAIL b2b_rx: got %h required %h", cap, e);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    logic [7:0] cap;
    act = 0;
    do_reset();
    rx_ready[0] = 1'b0;
    cs_low(0);
    xfer(0, 8'h11, 8, cap);
    xfer(0, 8'h22, 8, cap);
    cs_high(0);
    n_chk++;
    if ({rx_valid[0], rx_data[0]} !== {1'b1, 8'h22})
      $display("FAIL ovr_rx: got %b/%h required 1/22", rx_valid[0], rx_data[0]);
    else n_pass++;
    n_chk++;
    if (or_cnt != 1) $display("FAIL ovr_pulse: got %0d pulses required 1", or_cnt);
    else n_pass++;
    rx_ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (rx_valid[0] !== 1'b0) $display("FAIL ovr_consume: got %b required 0", rx_valid[0]);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] cap, e;
    act = 0;
    do_reset();
    cs_low(0);
    push_tx(0, 8'hE7); miso_exp.push_back(8'hE7);
    xfer(0, 8'hFF, 5, cap);
    cs_high(0);
    n_chk++;
    if (rv_cnt != 0 || tx_ready[0] !== 1'b0)
      $display("FAIL abort_partial: got rv=%0d tx_ready=%b required 0/0", rv_cnt, tx_ready[0]);
    else n_pass++;
    cs_low(0);
    rx_exp.push_back(8'h5A);
    xfer(0, 8'h5A, 8, cap);
    cs_high(0);
    e = miso_exp.pop_front();
    n_chk++;
    if (cap !== e) $display("FAIL abort_miso: got %h required %h", cap, e);
    else n_pass++;
    e = rx_exp.pop_front();
    n_chk++;
    if (got_q.size() != 1 || rx_data[0] !== e)
      $display("FAIL abort_rx: got %h (n=%0d) required %h", rx_data[0], got_q.size(), e);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] cap, e;
    act = 0;
    do_reset();
    push_tx(0, 8'hF0);
    cs_low(0);
    xfer(0, 8'h77, 8, cap);
    xfer(0, 8'h00, 3, cap);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({tx_ready[0], rx_valid[0], miso[0], miso_oe[0], busy[0], overrun[0], underrun[0], rx_data[0]} !==
        {7'b1000000, 8'h00})
      $display("FAIL midreset_outputs: got %b/%h required 1000000/00",
               {tx_ready[0], rx_valid[0], miso[0], miso_oe[0], busy[0], overrun[0], underrun[0]}, rx_data[0]);
    else n_pass++;
    cs[0] = 1'b1;
    sck = 4'b1100;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    got_q.delete();
    push_tx(0, 8'h29); miso_exp.push_back(8'h29);
    cs_low(0);
    rx_exp.push_back(8'hB4);
    xfer(0, 8'hB4, 8, cap);
    cs_high(0);
    e = miso_exp.pop_front();
    n_chk++;
    if (cap !== e) $display("FAIL midreset_miso: got %h required %h", cap, e);
    else n_pass++;
    e = rx_exp.pop_front();
    n_chk++;
    if (got_q.size() != 1 || rx_data[0] !== e)
      $display("FAIL midreset_rx: got %h (n=%0d) required %h", rx_data[0], got_q.size(), e);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_slave_cfg.md
SPI_SLAVE_CFG -- requirements
Module: spi_slave_cfg

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- SIZE, 8, word width in bits, 2..32.
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- LSB_FIRST, 0, 1 = shift LSB first, 0 = MSB first.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- sck, in, 1, SPI clock, asynchronous to clk.
- cs, in, 1, chip select, active-low, asynchronous.
- mosi, in, 1, serial data in, asynchronous.
- miso, out, 1, serial data out.
- miso_oe, out, 1, output enable; high while the synchronised cs is low.
- tx_data, in, SIZE, word to transmit.
- tx_valid, in, 1, tx_data offered.
- tx_ready, out, 1, TX holding register empty.
- rx_data, out, SIZE, last received word.
- rx_valid, out, 1, rx_data holds an unread word.
- rx_ready, in, 1, consumer takes rx_data.
- overrun, out, 1, one-cycle pulse: unread word overwritten.
- underrun, out, 1, one-cycle pulse: word started with empty TX register.
- busy, out, 1, synchronised cs is low.

Function
REQ-003 sck, cs and mosi SHALL each pass through a 2-flop synchroniser; all logic SHALL use the synchronised copies only.
REQ-004 Edge detection SHALL compare the synchronised sck against a third register; leading edge = transition away from CPOL, trailing edge = transition back to CPOL.
REQ-005 Sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other.
REQ-006 FSM states SHALL be IDLE, LOAD, ACTIVE.
- IDLE -> LOAD on synchronised cs falling.
- LOAD -> ACTIVE after exactly 1 clk.
- ACTIVE -> IDLE on synchronised cs high, from any state.
REQ-007 TX holding register: handshake on tx_valid && tx_ready; tx_ready SHALL be high when empty, low when full.
REQ-008 Word load (LOAD state, and after each completed word in ACTIVE) SHALL behave as follows:
- Holding register full: move it to the shift register and mark it empty.
- Holding register empty: load all zeros and pulse underrun.
REQ-009 Load timing:
- CPHA=0: the first bit SHALL be on miso before the first sck edge; subsequent words load on the shift edge that follows the SIZE-th sample.
- CPHA=1: each word SHALL load on the first leading edge of that word, with its first bit driven from that edge.
REQ-010 miso SHALL be shift[SIZE-1] (LSB_FIRST=0) or shift[0] (LSB_FIRST=1); miso SHALL be 0 when miso_oe is low.
REQ-011 Bit counter of CLOG2(SIZE) bits:
- Increment on each sample edge.
- Wrap to 0 after SIZE-1.
- Reset to 0 on cs high.
REQ-012 On the SIZE-th sample edge, rx_data SHALL update and rx_valid SHALL set 1 clk after that edge is detected (4 clk after the sck pin edge).
REQ-013 rx_valid SHALL clear on rx_ready && rx_valid.
REQ-014 Word completion while rx_valid is high and rx_ready is low SHALL overwrite rx_data, keep rx_valid high, and pulse overrun.
REQ-015 Word completion in the same cycle as rx_ready SHALL not pulse overrun; rx_valid SHALL stay high with the new word.
REQ-016 tx_valid accepted in the same cycle as a word load with an empty register SHALL still underrun; the accepted word SHALL be kept for the next word.
REQ-017 cs deassertion mid-word SHALL:
- Discard the partial RX word without asserting rx_valid.
- Discard the shift register contents.
- Keep the TX holding register and rx_data/rx_valid unchanged.
REQ-018 SCK edges while cs is high SHALL have no effect.
REQ-019 Operation SHALL be guaranteed for sck high and low phases of at least 4 clk each.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- FSM to IDLE.
- Synchronisers, shift register, counter and rx_data to 0.
- rx_valid, overrun, underrun, busy, miso and miso_oe to 0.
- tx_ready to 1 (holding register empty).
REQ-021 Reset release SHALL be synchronised internally, so the first clk edge after rst_n rises produces no spurious edge detection.

Verification
REQ-022 Mode 0, SIZE=8: tx_data=0xA5 loaded; master sends 0x3C -> miso yields 0xA5 MSB first; rx_data=0x3C; one rx_valid assertion.
REQ-023 Modes 1, 2, 3 with LSB_FIRST=1: master sends 0x01 -> rx_data=0x01; miso first bit = tx_data[0]; repeat for each mode.
REQ-024 Three back-to-back words in one cs frame, tx register empty on word 2 -> miso word 2 = 0x00; one underrun pulse; words 1 and 3 correct.
REQ-025 rx_ready held low across two words 0x11 then 0x22 -> rx_data=0x22; rx_valid high; one overrun pulse.
REQ-026 cs raised after 5 bits, then a new frame sends 0x5A -> no rx_valid for the partial word; rx_data=0x5A; bit counter restarts at 0.
REQ-027 rst_n asserted mid-frame -> all outputs at reset values in the same cycle; tx_ready=1; next frame works.
